// File: rtl/check_board_pkg.sv
// Shared board definitions: scan FSM states, colour type and board size limits.
// Also used by the board generator, so keep encodings stable.
package check_board_pkg;

    localparam int MAX_SIZE_DEF = 26;
    localparam int ADDR_W       = 5;
    localparam int NUM_COLORS   = 8;

    typedef logic [2:0] color_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] clamp_size(input logic [ADDR_W-1:0] s,
                                                     input int unsigned       max_s);
        return (32'(s) > max_s) ? ADDR_W'(max_s) : s;
    endfunction

endpackage

// File: rtl/check_board_addr_walk.sv
// Row-major address walker: (0,0) .. (size-1,size-1), one address per cycle.
// Counters sit at 0 whenever no walk is in progress.
module board_addr_walk
    import check_board_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] size,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic              last
);

    logic              active;
    logic [ADDR_W-1:0] edge_m1;

    assign edge_m1 = size - ADDR_W'(1);
    assign last    = active && (row == edge_m1) && (col == edge_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            row    <= '0;
            col    <= '0;
        end else if (start) begin
            active <= 1'b1;
            row    <= '0;
            col    <= '0;
        end else if (active) begin
            if (last) begin
                active <= 1'b0;
                row    <= '0;
                col    <= '0;
            end else if (col == edge_m1) begin
                col <= '0;
                row <= row + ADDR_W'(1);
            end else begin
                col <= col + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/check_board.sv
// Board checker: scans a SIZE x SIZE board and counts cells differing from cell (0,0).
// Optional per-colour histogram is built when CHECK_BOARD_HIST_EN is defined.
module check_board
    import check_board_pkg::*;
#(
    parameter int MAX_SIZE = MAX_SIZE_DEF,
    parameter int CNT_W    = 10
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic [4:0]            SIZE,
    output logic                  RD_EN,
    output logic [4:0]            RD_ROW,
    output logic [4:0]            RD_COL,
    input  logic [2:0]            RD_DATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  SOLVED,
    output logic [CNT_W-1:0]      MISMATCH,
    output logic [8*CNT_W-1:0]    COLOR_COUNT
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] size_c, size_q;
    logic [ADDR_W-1:0] w_row, w_col;
    logic              w_last;
    logic              start_acc;
    logic              rd_en, finish;
    logic              rd_vld_q;
    logic              first_q;
    color_t            ref_q;

    assign size_c    = clamp_size(SIZE, MAX_SIZE);
    assign start_acc = (state == ST_IDLE) && START;

    board_addr_walk u_walk (
        .clk   (CLOCK),
        .rst_n (RESET_N),
        .start (start_acc && (size_c != '0)),
        .size  (size_q),
        .row   (w_row),
        .col   (w_col),
        .last  (w_last)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (START) state_nxt = (size_c == '0) ? ST_FINISH : ST_SCAN;
            ST_SCAN:   if (w_last) state_nxt = ST_DRAIN;
            ST_DRAIN:  state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_en  = 1'b0;
        finish = 1'b0;
        unique case (state)
            ST_SCAN:   rd_en  = 1'b1;
            ST_FINISH: finish = 1'b1;
            default:   ;
        endcase
    end

    assign RD_EN  = rd_en;
    assign RD_ROW = rd_en ? w_row : '0;
    assign RD_COL = rd_en ? w_col : '0;

    // RD_DATA lags RD_EN by one cycle; the first returned cell is the reference.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            size_q   <= '0;
            rd_vld_q <= 1'b0;
            first_q  <= 1'b0;
            ref_q    <= '0;
            MISMATCH <= '0;
            SOLVED   <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            rd_vld_q <= rd_en;
            DONE     <= finish;
            if (start_acc) begin
                size_q   <= size_c;
                first_q  <= 1'b1;
                MISMATCH <= '0;
                SOLVED   <= 1'b0;
                BUSY     <= 1'b1;
            end else begin
                if (rd_vld_q) begin
                    if (first_q) begin
                        ref_q   <= RD_DATA;
                        first_q <= 1'b0;
                    end else if (RD_DATA != ref_q) begin
                        MISMATCH <= MISMATCH + CNT_W'(1);
                    end
                end
                if (finish) begin
                    SOLVED <= (MISMATCH == '0);
                    BUSY   <= 1'b0;
                end
            end
        end
    end

`ifdef CHECK_BOARD_HIST_EN
    logic [NUM_COLORS-1:0][CNT_W-1:0] hist;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)      hist <= '0;
        else if (start_acc) hist <= '0;
        else if (rd_vld_q) hist[RD_DATA] <= hist[RD_DATA] + CNT_W'(1);
    end

    assign COLOR_COUNT = hist;
`else
    assign COLOR_COUNT = '0;
`endif

endmodule
